// File: rtl/mem_mailbox_monitor.sv
// Passive mailbox snooper: latches the byte-swapped software verdict, runs a boot watchdog and reports a sticky result.
// Latency: one cycle after the accepting edge, with every output registered. Backpressure: none; it only observes and never drives the bus.
module mem_mailbox_monitor #(
  parameter logic [31:0] P_MAILBOX_BASE = 32'h0002_0000,
  parameter logic [31:0] P_TIMEOUT      = 32'd750000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oDONE,
  output logic        oPASS,
  output logic        oTIMEOUT,
  output logic [31:0] oWRONG_TYPE,
  output logic [31:0] oWRONG_INDEX,
  output logic [31:0] oRESULT,
  output logic [31:0] oEXPECT,
  output logic [15:0] oWRITE_COUNT
);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t      state_q, state_d;
  logic        flag_q, flag_d;
  logic [31:0] wtype_q, wtype_d;
  logic [31:0] windex_q, windex_d;
  logic [31:0] result_q, result_d;
  logic [31:0] expect_q, expect_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic [15:0] wcount_q, wcount_d;

  logic        wr_acc;
  logic        mb_hit;
  logic        fin_hit;
  logic        wd_expire;
  logic [31:0] swapped;

  // Software writes little-endian words; the bus presents them byte-reversed.
  assign swapped = {iMEMORY_DATA[7:0], iMEMORY_DATA[15:8],
                    iMEMORY_DATA[23:16], iMEMORY_DATA[31:24]};

  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    wtype_d   = wtype_q;
    windex_d  = windex_q;
    result_d  = result_q;
    expect_d  = expect_q;
    wd_cnt_d  = wd_cnt_q;
    wcount_d  = wcount_q;
    mb_hit    = 1'b1;
    fin_hit   = 1'b0;

    wr_acc    = iMEMORY_REQ & ~iMEMORY_LOCK & (iMEMORY_ORDER == 2'h2) & iMEMORY_RW;
    wd_expire = (P_TIMEOUT != 32'd0) && (wd_cnt_q == P_TIMEOUT - 32'd1);

    case (iMEMORY_ADDR)
      P_MAILBOX_BASE + 32'h00: if (wr_acc) flag_d   = iMEMORY_DATA[24];
      P_MAILBOX_BASE + 32'h04: fin_hit = wr_acc;
      P_MAILBOX_BASE + 32'h08: if (wr_acc) wtype_d  = swapped;
      P_MAILBOX_BASE + 32'h0C: if (wr_acc) windex_d = swapped;
      P_MAILBOX_BASE + 32'h10: if (wr_acc) result_d = swapped;
      P_MAILBOX_BASE + 32'h14: if (wr_acc) expect_d = swapped;
      default:                 mb_hit = 1'b0;
    endcase

    if (state_q == ST_RUN) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
      if (wr_acc && mb_hit && (wcount_q != 16'hFFFF)) begin
        wcount_d = wcount_q + 16'd1;
      end
      // A finish on the expiry cycle still reports the software verdict.
      if (fin_hit) begin
        state_d = flag_q ? ST_PASS : ST_FAIL;
      end else if (wd_expire) begin
        state_d = ST_TIMEOUT;
      end
    end else begin
      flag_d   = flag_q;
      wtype_d  = wtype_q;
      windex_d = windex_q;
      result_d = result_q;
      expect_d = expect_q;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q  <= ST_RUN;
      flag_q   <= 1'b0;
      wtype_q  <= 32'd0;
      windex_q <= 32'd0;
      result_q <= 32'd0;
      expect_q <= 32'd0;
      wd_cnt_q <= 32'd0;
      wcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      wtype_q  <= wtype_d;
      windex_q <= windex_d;
      result_q <= result_d;
      expect_q <= expect_d;
      wd_cnt_q <= wd_cnt_d;
      wcount_q <= wcount_d;
    end
  end

  assign oDONE        = (state_q != ST_RUN);
  assign oPASS        = (state_q == ST_PASS);
  assign oTIMEOUT     = (state_q == ST_TIMEOUT);
  assign oWRONG_TYPE  = wtype_q;
  assign oWRONG_INDEX = windex_q;
  assign oRESULT      = result_q;
  assign oEXPECT      = expect_q;
  assign oWRITE_COUNT = wcount_q;

endmodule
